// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Holds the session state encoding, memory depth and header framing size.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam int ADDR_W_DEFAULT = 12;
    localparam int DEPTH          = 2 ** ADDR_W_DEFAULT;
    localparam int HDR_BYTES      = 4;

    // 33 bits so a full 32-bit header count can be compared without overflow.
    function automatic logic [32:0] depth_words(input int addr_w);
        depth_words = 33'd1 << addr_w;
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot-time loader: unpacks a framed byte stream into 32-bit words, writes them
// to the instruction memory and keeps the core held until a checksum-valid load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEFAULT,
    parameter bit HOLD_AT_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [32:0] DEPTH_W = depth_words(ADDR_W);
    localparam logic [1:0]  LAST_IDX = 2'(HDR_BYTES - 1);

    state_t            state, state_next;
    logic [1:0]        byte_idx;
    logic [23:0]       hdr_shift;
    logic [23:0]       word_buf;
    logic [7:0]        csum;
    logic [ADDR_W:0]   word_count;
    logic [31:0]       hdr_next;
    logic              in_session;
    logic              can_start;
    logic              accept;
    logic              last_word;

    assign in_session = (state == HDR) || (state == DATA) || (state == CSUM);
    assign can_start  = (state == IDLE) || (state == DONE) || (state == ERR);
    assign accept     = s_valid && in_session;
    assign hdr_next   = {s_data, hdr_shift};
    assign last_word  = (words_loaded + 1'b1) == word_count;

    assign s_ready   = in_session;
    assign busy      = in_session;
    assign done      = (state == DONE);
    assign err       = (state == ERR);
    // Only IDLE after reset may leave the core running; DONE is the sole release.
    assign core_hold = (state == DONE) ? 1'b0 :
                       (state == IDLE) ? HOLD_AT_RESET : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_next = HDR;
                end
            end
            HDR: begin
                if (accept && byte_idx == LAST_IDX) begin
                    if ({1'b0, hdr_next} > DEPTH_W) begin
                        state_next = ERR;
                    end else if (hdr_next == 32'd0) begin
                        state_next = CSUM;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (accept && byte_idx == LAST_IDX && last_word) begin
                    state_next = CSUM;
                end
            end
            CSUM: begin
                if (accept) begin
                    state_next = (s_data == csum) ? DONE : ERR;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Byte packing, checksum and write-port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx     <= 2'd0;
            hdr_shift    <= 24'd0;
            word_buf     <= 24'd0;
            csum         <= 8'd0;
            word_count   <= '0;
            words_loaded <= '0;
            imem_we      <= 1'b0;
            imem_waddr   <= '0;
            imem_wdata   <= 32'd0;
        end else begin
            imem_we <= 1'b0;
            if (start && can_start) begin
                byte_idx     <= 2'd0;
                csum         <= 8'd0;
                words_loaded <= '0;
            end else if (accept) begin
                case (state)
                    HDR: begin
                        hdr_shift <= {s_data, hdr_shift[23:8]};
                        byte_idx  <= byte_idx + 2'd1;
                        if (byte_idx == LAST_IDX) begin
                            word_count <= hdr_next[ADDR_W:0];
                        end
                    end
                    DATA: begin
                        csum     <= csum ^ s_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= s_data;
                            2'd1: word_buf[15:8]  <= s_data;
                            2'd2: word_buf[23:16] <= s_data;
                            default: begin
                                imem_we      <= 1'b1;
                                imem_wdata   <= {s_data, word_buf};
                                imem_waddr   <= words_loaded[ADDR_W-1:0];
                                words_loaded <= words_loaded + 1'b1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, checksum errors, oversize and
// empty headers, throttled sources and asynchronous reset in mid-session.
module tb_imem_loader;

    localparam int ADDR_W = 12;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              core_hold;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    int tests;
    int failures;

    logic [ADDR_W-1:0] wr_addr [64];
    logic [31:0]       wr_data [64];
    int                wr_total;

    imem_loader #(.ADDR_W(ADDR_W), .HOLD_AT_RESET(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .imem_we      (imem_we),
        .imem_waddr   (imem_waddr),
        .imem_wdata   (imem_wdata),
        .core_hold    (core_hold),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every write strobe seen between rising edges.
    always @(negedge clk) begin
        if (imem_we) begin
            if (wr_total < 64) begin
                wr_addr[wr_total] <= imem_waddr;
                wr_data[wr_total] <= imem_wdata;
            end
            wr_total <= wr_total + 1;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int budget;
        budget  = 0;
        s_data  = b;
        s_valid = 1'b1;
        while (!s_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!s_ready) begin
            $display("[TB] FAIL send_timeout: s_ready got %b expected 1 (byte %h)", s_ready, b);
            failures++;
            tests++;
            s_valid = 1'b0;
            return;
        end
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_good_stream(input logic [7:0] last);
        logic [7:0] bytes [13];
        bytes = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
                  8'h93, 8'h00, 8'hA0, 8'h00, 8'h70};
        bytes[12] = last;
        for (int i = 0; i < 13; i++) send_byte(bytes[i]);
        s_valid = 1'b0;
        #1;
    endtask

    task automatic check_two_writes(input string tag, input int base);
        if (wr_total - base !== 2) begin
            $display("[TB] FAIL %s_write_count: got %0d expected 2", tag, wr_total - base);
            failures++;
        end
        tests++;
        if (wr_addr[base] !== 12'd0 || wr_data[base] !== 32'h0050_0013) begin
            $display("[TB] FAIL %s_word0: got [%0d]=%h expected [0]=00500013", tag, wr_addr[base], wr_data[base]);
            failures++;
        end
        tests++;
        if (wr_addr[base+1] !== 12'd1 || wr_data[base+1] !== 32'h00A0_0093) begin
            $display("[TB] FAIL %s_word1: got [%0d]=%h expected [1]=00a00093", tag, wr_addr[base+1], wr_data[base+1]);
            failures++;
        end
        tests++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        if ({s_ready, busy, done, err, imem_we, core_hold} !== 6'b000001) begin
            $display("[TB] FAIL reset_flags: got rdy/busy/done/err/we/hold=%b expected 000001",
                     {s_ready, busy, done, err, imem_we, core_hold});
            failures++;
        end
        tests++;
        if (imem_waddr !== 12'd0 || imem_wdata !== 32'd0 || words_loaded !== 13'd0) begin
            $display("[TB] FAIL reset_regs: got waddr=%h wdata=%h words=%0d expected 0/0/0",
                     imem_waddr, imem_wdata, words_loaded);
            failures++;
        end
        tests++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_load();
        int base;
        base = wr_total;
        pulse_start();
        if (s_ready !== 1'b1 || busy !== 1'b1) begin
            $display("[TB] FAIL good_hdr_ready: got ready=%b busy=%b expected 1/1", s_ready, busy);
            failures++;
        end
        tests++;
        send_good_stream(8'h70);
        check_two_writes("good", base);
        if (done !== 1'b1 || err !== 1'b0 || core_hold !== 1'b0 || s_ready !== 1'b0) begin
            $display("[TB] FAIL good_status: got done=%b err=%b hold=%b ready=%b expected 1/0/0/0",
                     done, err, core_hold, s_ready);
            failures++;
        end
        tests++;
        if (words_loaded !== 13'd2) begin
            $display("[TB] FAIL good_words: got %0d expected 2", words_loaded);
            failures++;
        end
        tests++;
        @(negedge clk);
    endtask

    task automatic test_bad_checksum();
        int base;
        base = wr_total;
        pulse_start();
        send_good_stream(8'h71);
        check_two_writes("badcs", base);
        if (err !== 1'b1 || done !== 1'b0 || core_hold !== 1'b1) begin
            $display("[TB] FAIL badcs_status: got err=%b done=%b hold=%b expected 1/0/1", err, done, core_hold);
            failures++;
        end
        tests++;
        if (words_loaded !== 13'd2) begin
            $display("[TB] FAIL badcs_words: got %0d expected 2", words_loaded);
            failures++;
        end
        tests++;
        @(negedge clk);
    endtask

    task automatic test_oversize();
        int base;
        base = wr_total;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h10);
        send_byte(8'h00);
        send_byte(8'h00);
        s_valid = 1'b0;
        if (err !== 1'b1 || s_ready !== 1'b0 || done !== 1'b0) begin
            $display("[TB] FAIL oversize_err: got err=%b ready=%b done=%b expected 1/0/0", err, s_ready, done);
            failures++;
        end
        tests++;
        repeat (3) @(negedge clk);
        #1;
        if (wr_total - base !== 0) begin
            $display("[TB] FAIL oversize_writes: got %0d expected 0", wr_total - base);
            failures++;
        end
        tests++;
    endtask

    task automatic test_zero_length();
        int base;
        base = wr_total;
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(8'h00);
        s_valid = 1'b0;
        #1;
        if (done !== 1'b1 || core_hold !== 1'b0 || words_loaded !== 13'd0) begin
            $display("[TB] FAIL zero_status: got done=%b hold=%b words=%0d expected 1/0/0",
                     done, core_hold, words_loaded);
            failures++;
        end
        tests++;
        if (wr_total - base !== 0) begin
            $display("[TB] FAIL zero_writes: got %0d expected 0", wr_total - base);
            failures++;
        end
        tests++;
        @(negedge clk);
    endtask

    task automatic test_throttled();
        int base;
        logic [7:0] bytes [13];
        bytes = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
                  8'h93, 8'h00, 8'hA0, 8'h00, 8'h70};
        base = wr_total;
        pulse_start();
        for (int i = 0; i < 13; i++) begin
            send_byte(bytes[i]);
            s_valid = 1'b0;
            if (i == 6) pulse_start();
            repeat ($urandom_range(5, 0)) @(negedge clk);
        end
        #1;
        check_two_writes("throttle", base);
        if (done !== 1'b1 || core_hold !== 1'b0 || words_loaded !== 13'd2) begin
            $display("[TB] FAIL throttle_status: got done=%b hold=%b words=%0d expected 1/0/2",
                     done, core_hold, words_loaded);
            failures++;
        end
        tests++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_data();
        int base;
        logic [7:0] bytes [10];
        bytes = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00};
        base = wr_total;
        pulse_start();
        for (int i = 0; i < 10; i++) send_byte(bytes[i]);
        s_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        if ({s_ready, busy, done, err, imem_we, core_hold} !== 6'b000001 || words_loaded !== 13'd0) begin
            $display("[TB] FAIL midrst_outputs: got rdy/busy/done/err/we/hold=%b words=%0d expected 000001/0",
                     {s_ready, busy, done, err, imem_we, core_hold}, words_loaded);
            failures++;
        end
        tests++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        if (wr_total - base !== 1 || wr_data[base] !== 32'h0050_0013) begin
            $display("[TB] FAIL midrst_writes: got count=%0d data=%h expected 1/00500013",
                     wr_total - base, wr_data[base]);
            failures++;
        end
        tests++;
        @(negedge clk);
        test_good_load();
    endtask

    initial begin
        tests    = 0;
        failures = 0;
        wr_total = 0;
        start    = 1'b0;
        s_valid  = 1'b0;
        s_data   = 8'h00;
        rst_n    = 1'b1;
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_oversize();
        test_zero_length();
        test_throttled();
        test_reset_mid_data();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
